// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : riscv_pkg
// Purpose : Shared RV32I types and constants (fetch entry, reset PC).
// Revision: 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fetch_fifo
// Purpose : Synchronous FIFO of fetch entries; flush wins over push.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(push && full && !pop && !flush))
    else $error("fetch_fifo overflow");

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fetch_stage
// Purpose : RV32I fetch: PC, credit-limited imem requests, response buffering.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  r_req_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_hs;
  logic             w_drop;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;

  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign valid_o       = ~w_empty;
  assign w_pop         = valid_o & ~stall_i & ~redirect_i;

  // Credit: buffered + in-flight (after this cycle's pop) must stay below depth.
  assign w_occupancy      = {1'b0, w_count} + {1'b0, r_outstanding} - {{CNT_W{1'b0}}, w_pop};
  assign imem_req_valid_o = rst_ni & ~redirect_i & (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr_o  = r_req_pc;
  assign w_hs             = imem_req_valid_o & imem_req_ready_i;

  assign w_drop       = imem_rsp_valid_i & (r_drop_cnt != '0);
  assign w_push       = imem_rsp_valid_i & ~w_drop & ~redirect_i;
  assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data_i};

  assign instr_o = valid_o ? w_head.instr : '0;
  assign pc_o    = valid_o ? w_head.pc    : r_rsp_pc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_pc      <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      r_req_pc      <= w_redirect_pc;
      r_rsp_pc      <= w_redirect_pc;
      r_outstanding <= r_outstanding - CNT_W'(imem_rsp_valid_i);
      r_drop_cnt    <= r_outstanding - CNT_W'(imem_rsp_valid_i);
    end else begin
      if (w_hs)   r_req_pc   <= r_req_pc + XLEN'(4);
      if (w_push) r_rsp_pc   <= r_rsp_pc + XLEN'(4);
      if (w_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
      r_outstanding <= r_outstanding + CNT_W'(w_hs) - CNT_W'(imem_rsp_valid_i);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (w_push),
    .pop    (w_pop),
    .flush  (redirect_i),
    .wdata  (w_push_entry),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  a_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
                             !(w_push && w_full && !w_pop))
    else $error("fetch_stage response exceeded credit");

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_fetch_stage
// Purpose : Self-checking bench for fetch_stage with an in-order imem model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .stall_i          (stall_i),
    .valid_o          (valid_o),
    .instr_o          (instr_o),
    .pc_o             (pc_o)
  );

  typedef struct { logic [31:0] a; int t; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic stall; logic exp_valid; logic exp_req; logic [31:0] exp_pc; } row_t;

  mreq_t       mq[$];
  exp_t        exp_q[$];
  row_t        tbl[12];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          dmin = 1;
  int          dmax = 1;
  logic [31:0] exp_req_pc = RST_PC;
  logic        s_hs;
  logic [31:0] s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else n_pass++;
  endtask

  // Negedge: scoreboard the cycle. Posedge+1: advance the memory model.
  task automatic cycle();
    exp_t e;
    @(negedge clk_i);
    s_hs   = imem_req_valid_o && imem_req_ready_i;
    s_addr = imem_req_addr_o;
    if (redirect_i) begin
      chk("no_req_on_redirect", {31'b0, imem_req_valid_o}, 32'd0);
      exp_q.delete();
      exp_req_pc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_pop: got pc %h, required no entry", pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", pc_o, e.pc);
          chk("sb_instr", instr_o, e.instr);
        end
      end
      if (s_hs) begin
        chk("req_addr", s_addr, exp_req_pc);
        exp_q.push_back('{exp_req_pc, mem_word(exp_req_pc)});
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
    @(posedge clk_i);
    #1;
    if (s_hs && rst_ni) mq.push_back('{s_addr, cyc + $urandom_range(dmax, dmin) - 1});
    if (mq.size() > 0 && mq[0].t <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
    end
    cyc++;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    #3;
    while (!valid_o && n < 20) begin
      cycle();
      #3;
      n++;
    end
    if (!valid_o) begin
      n_checks++;
      $display("FAIL %s_timeout: got valid_o 0, required 1 within 20 cycles", name);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h4};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h8};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h8};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h8};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h8};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h8};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h8};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'hC};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h10};

    // Reset state
    repeat (3) cycle();
    #3;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, RST_PC);
    cycle();
    rst_ni = 1'b1;

    // Startup latency, streaming, 5-cycle stall with 0x8 at head
    for (int i = 0; i < 12; i++) begin
      stall_i = tbl[i].stall;
      #3;
      chk($sformatf("row%0d_valid", i), {31'b0, valid_o}, {31'b0, tbl[i].exp_valid});
      chk($sformatf("row%0d_req", i), {31'b0, imem_req_valid_o}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_valid) chk($sformatf("row%0d_pc", i), pc_o, tbl[i].exp_pc);
      cycle();
    end
    stall_i = 1'b0;

    // Redirect with one request in flight whose response lands next cycle
    imem_req_ready_i = 1'b0;
    repeat (4) cycle();
    dmin = 2; dmax = 2;
    imem_req_ready_i = 1'b1;
    cycle();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    cycle();
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    dmin = 1; dmax = 1;
    wait_valid("redir_a");
    chk("redir_a_pc", pc_o, 32'h0000_0100);
    chk("redir_a_instr", instr_o, mem_word(32'h0000_0100));
    cycle();

    // Redirect in the cycle a response lands, with one more still outstanding
    imem_req_ready_i = 1'b0;
    repeat (4) cycle();
    dmin = 2; dmax = 2;
    imem_req_ready_i = 1'b1;
    cycle();
    cycle();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    cycle();
    redirect_i = 1'b0;
    dmin = 1; dmax = 1;
    wait_valid("redir_b");
    chk("redir_b_pc", pc_o, 32'h0000_0200);
    chk("redir_b_instr", instr_o, mem_word(32'h0000_0200));
    cycle();

    // Random ready, 1-3 cycle latency, stalls and occasional redirects
    dmin = 1; dmax = 3;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready_i = $urandom_range(1, 0) == 1;
      stall_i          = $urandom_range(3, 0) == 0;
      redirect_i       = $urandom_range(39, 0) == 0;
      redirect_pc_i    = $urandom & 32'h0000_FFFF;
      cycle();
    end
    redirect_i = 1'b0;
    stall_i = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (6) cycle();

    // Asynchronous reset mid-stream with a full FIFO
    dmin = 1; dmax = 1;
    stall_i = 1'b1;
    repeat (4) cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_pc", pc_o, RST_PC);
    mq.delete();
    exp_q.delete();
    imem_rsp_valid_i = 1'b0;
    exp_req_pc = RST_PC;
    stall_i = 1'b0;
    repeat (2) cycle();
    rst_ni = 1'b1;
    wait_valid("post_rst");
    chk("post_rst_pc", pc_o, RST_PC);
    chk("post_rst_instr", instr_o, mem_word(RST_PC));
    repeat (10) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
